id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register directly downstream of the register file.
- Captures RD1/RD2 plus decoded fields at the end of ID.
- Applies write-back bypass for same-cycle register-file writes, which the register file does not provide: it writes on posedge and reads asynchronously.
- Detects load-use hazards and inserts bubbles; honours stall/flush from the control unit.
- Keeps saturating stall and bubble counters for debug.

Parameters:
- XLEN, 32, datapath width.
- CTRLW, 12, width of decoded control bundle passed to EX/MEM/WB.
- LOAD_BIT, 0, index in ctrl bundle marking a load (mem-read) instruction.
- CNTW, 16, width of debug counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold EX-stage contents (downstream busy).
- flush_i  in  1  kill instruction entering EX (branch/jump redirect).
- valid_i  in  1  ID holds a real instruction.
- pc_i  in  XLEN  PC of ID instruction.
- rs1_i, rs2_i, rd_i  in  5  register indices (A1, A2, destination).
- rd1_i, rd2_i  in  XLEN  register-file read data RD1/RD2.
- imm_i  in  XLEN  sign-extended immediate.
- ctrl_i  in  CTRLW  decoded control bundle.
- wb_we_i  in  1  write-back enable (same signal as register-file WE3).
- wb_rd_i  in  5  write-back index (A3).
- wb_data_i  in  XLEN  write-back data (WD3).
- hazard_o  out  1  load-use detected; IF/ID must hold (combinational).
- valid_o  out  1  EX instruction valid.
- pc_o, imm_o  out  XLEN  registered copies.
- rs1_o, rs2_o, rd_o  out  5  registered indices.
- op_a_o, op_b_o  out  XLEN  registered (bypassed) operands.
- ctrl_o  out  CTRLW  registered control; forced 0 when bubble.
- stall_cnt_o  out  CNTW  cycles with stall_i=1, saturating.
- bubble_cnt_o  out  CNTW  bubbles inserted (hazard or flush), saturating.

Behaviour:
- Reset (async, immediate): every registered output and both counters = 0; valid_o=0. Reset mid-operation discards the EX instruction.
- Bypass on capture: fa = (wb_we_i && wb_rd_i!=0 && wb_rd_i==rs1_i) ? wb_data_i : rd1_i; fb likewise for rs2_i. Index 0 is never bypassed; operands from x0 stay as read (0).
- hazard_o = valid_o && ctrl_o[LOAD_BIT] && rd_o!=0 && valid_i && (rd_o==rs1_i || rd_o==rs2_i), gated by !stall_i && !flush_i.
- Per-edge priority, highest first:
  1. flush_i: load bubble (valid_o=0, ctrl_o=0, other fields don't-care but zeroed). bubble_cnt++ if flush_i overrides a valid_i=1 instruction, or if stall_i is also set.
  2. stall_i: hold all fields. Refresh held operands: if wb_we_i && wb_rd_i!=0 && wb_rd_i==rs1_o then op_a_o<=wb_data_i (same for rs2_o/op_b_o). stall_cnt++.
  3. hazard_o: load bubble, bubble_cnt++. Upstream holds, so the same instruction re-presents next cycle.
  4. otherwise: capture inputs with bypass; valid_o<=valid_i; ctrl_o<=valid_i?ctrl_i:0.
- Latency: 1 cycle ID→EX. A hazard costs exactly 1 bubble.
- Counters saturate at all-ones. No wrap.
- flush_i and stall_i together: flush wins; stall_cnt does not increment.

Test Plan:
- Reset: assert rst between edges → all outputs 0 immediately, before next clk; counters 0.
- Plain capture: valid_i=1, rs1=3, rd1_i=0x11, rs2=4, rd2_i=0x22, wb_we_i=0 → next edge op_a_o=0x11, op_b_o=0x22, valid_o=1.
- WB bypass: rs1_i=5, rd1_i=0xAAAA, wb_we_i=1, wb_rd_i=5, wb_data_i=0x1234 → op_a_o=0x1234. Repeat with rs1_i=wb_rd_i=0 → op_a_o=rd1_i.
- Load-use: EX holds load (ctrl_o[0]=1, rd_o=7); ID rs2_i=7 → hazard_o=1, next edge valid_o=0, ctrl_o=0, bubble_cnt_o=1. Following edge captures the instruction.
- Stall with refresh: stall_i=1 for 3 cycles, rs1_o=9; cycle 2 wb_we_i=1, wb_rd_i=9, wb_data_i=0xBEEF → op_a_o=0xBEEF, other fields unchanged, stall_cnt_o=3.
- Flush+stall same cycle: flush wins → valid_o=0, stall_cnt_o unchanged, bubble_cnt_o+1. Counter saturation: preload via 0xFFFF stalls → holds 0xFFFF.

Source files
------------

// File: rtl/id_ex_if.sv
// id_ex_if: ID-side inputs and EX-side outputs of the decode-to-execute pipeline register
interface id_ex_if #(
   parameter int XLEN  = 32,
   parameter int CTRLW = 12,
   parameter int CNTW  = 16
);
   logic             stall_i;
   logic             flush_i;
   logic             valid_i;
   logic [XLEN-1:0]  pc_i;
   logic [4:0]       rs1_i;
   logic [4:0]       rs2_i;
   logic [4:0]       rd_i;
   logic [XLEN-1:0]  rd1_i;
   logic [XLEN-1:0]  rd2_i;
   logic [XLEN-1:0]  imm_i;
   logic [CTRLW-1:0] ctrl_i;
   logic             wb_we_i;
   logic [4:0]       wb_rd_i;
   logic [XLEN-1:0]  wb_data_i;
   logic             hazard_o;
   logic             valid_o;
   logic [XLEN-1:0]  pc_o;
   logic [XLEN-1:0]  imm_o;
   logic [4:0]       rs1_o;
   logic [4:0]       rs2_o;
   logic [4:0]       rd_o;
   logic [XLEN-1:0]  op_a_o;
   logic [XLEN-1:0]  op_b_o;
   logic [CTRLW-1:0] ctrl_o;
   logic [CNTW-1:0]  stall_cnt_o;
   logic [CNTW-1:0]  bubble_cnt_o;
   modport master (
      output stall_i, flush_i, valid_i, pc_i, rs1_i, rs2_i, rd_i, rd1_i, rd2_i, imm_i, ctrl_i,
             wb_we_i, wb_rd_i, wb_data_i,
      input  hazard_o, valid_o, pc_o, imm_o, rs1_o, rs2_o, rd_o, op_a_o, op_b_o, ctrl_o,
             stall_cnt_o, bubble_cnt_o
   );
   modport slave (
      input  stall_i, flush_i, valid_i, pc_i, rs1_i, rs2_i, rd_i, rd1_i, rd2_i, imm_i, ctrl_i,
             wb_we_i, wb_rd_i, wb_data_i,
      output hazard_o, valid_o, pc_o, imm_o, rs1_o, rs2_o, rd_o, op_a_o, op_b_o, ctrl_o,
             stall_cnt_o, bubble_cnt_o
   );
endinterface

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with write-back bypass, load-use bubbles and debug counters
module id_ex_stage_reg #(
   parameter int XLEN     = 32,
   parameter int CTRLW    = 12,
   parameter int LOAD_BIT = 0,
   parameter int CNTW     = 16
) (
   input logic   clk,
   input logic   rst,
   id_ex_if.slave bus
);
   logic             valid_q, valid_d;
   logic [XLEN-1:0]  pc_q, pc_d, imm_q, imm_d, op_a_q, op_a_d, op_b_q, op_b_d;
   logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [CTRLW-1:0] ctrl_q, ctrl_d;
   logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
   logic             hazard, load_bubble, wb_hit;
   logic [XLEN-1:0]  fa, fb;
   always_comb begin
      wb_hit = bus.wb_we_i && bus.wb_rd_i != 5'd0;
      fa = (wb_hit && bus.wb_rd_i == bus.rs1_i) ? bus.wb_data_i : bus.rd1_i;
      fb = (wb_hit && bus.wb_rd_i == bus.rs2_i) ? bus.wb_data_i : bus.rd2_i;
      hazard = valid_q && ctrl_q[LOAD_BIT] && rd_q != 5'd0 && bus.valid_i &&
               (rd_q == bus.rs1_i || rd_q == bus.rs2_i) && !bus.stall_i && !bus.flush_i;
      load_bubble = bus.flush_i || hazard;
      valid_d = !load_bubble && (bus.stall_i ? valid_q : bus.valid_i);
      pc_d    = load_bubble ? '0 : bus.stall_i ? pc_q  : bus.pc_i;
      imm_d   = load_bubble ? '0 : bus.stall_i ? imm_q : bus.imm_i;
      rs1_d   = load_bubble ? '0 : bus.stall_i ? rs1_q : bus.rs1_i;
      rs2_d   = load_bubble ? '0 : bus.stall_i ? rs2_q : bus.rs2_i;
      rd_d    = load_bubble ? '0 : bus.stall_i ? rd_q  : bus.rd_i;
      ctrl_d  = load_bubble ? '0 : bus.stall_i ? ctrl_q : (bus.valid_i ? bus.ctrl_i : '0);
      // a held instruction must still see results written back while it waits
      op_a_d  = load_bubble ? '0 : bus.stall_i ? ((wb_hit && bus.wb_rd_i == rs1_q) ? bus.wb_data_i : op_a_q) : fa;
      op_b_d  = load_bubble ? '0 : bus.stall_i ? ((wb_hit && bus.wb_rd_i == rs2_q) ? bus.wb_data_i : op_b_q) : fb;
      stall_cnt_d  = (bus.stall_i && !bus.flush_i) ?
                     stall_cnt_q + {{(CNTW-1){1'b0}}, ~&stall_cnt_q} : stall_cnt_q;
      bubble_cnt_d = (bus.flush_i ? (bus.valid_i || bus.stall_i) : hazard) ?
                     bubble_cnt_q + {{(CNTW-1){1'b0}}, ~&bubble_cnt_q} : bubble_cnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q      <= 1'b0;
         pc_q         <= '0;
         imm_q        <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rd_q         <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         ctrl_q       <= '0;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         pc_q         <= pc_d;
         imm_q        <= imm_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         rd_q         <= rd_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         ctrl_q       <= ctrl_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end
   assign bus.hazard_o     = hazard;
   assign bus.valid_o      = valid_q;
   assign bus.pc_o         = pc_q;
   assign bus.imm_o        = imm_q;
   assign bus.rs1_o        = rs1_q;
   assign bus.rs2_o        = rs2_q;
   assign bus.rd_o         = rd_q;
   assign bus.op_a_o       = op_a_q;
   assign bus.op_b_o       = op_b_q;
   assign bus.ctrl_o       = ctrl_q;
   assign bus.stall_cnt_o  = stall_cnt_q;
   assign bus.bubble_cnt_o = bubble_cnt_q;
endmodule
